// File: rtl/wbuf_pkg.sv
// wbuf_pkg: shared types and sizing helpers for the ping-pong weight buffer.
package wbuf_pkg;

    typedef enum logic [1:0] {MODE_STD = 2'd0, MODE_DW = 2'd1} wbuf_mode_e;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FULL = 2'd2} wbuf_state_e;

    function automatic int calc_wpr(int col_num, int data_w, int bus_w);
        return col_num * data_w / bus_w;
    endfunction

    function automatic int calc_dw_rows(int row_num, int ksize);
        return (row_num / ksize) * ksize;
    endfunction

    function automatic int idx_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int WPR = calc_wpr(32, 8, 32);
    localparam int DW_ROWS = calc_dw_rows(32, 3);

endpackage

// File: rtl/wbuf_bank.sv
// wbuf_bank: one weight bank of ROW_NUM x WPR bus words, single write port,
// synchronous clear and flat read-out in PE order.
module wbuf_bank
    import wbuf_pkg::*;
#(
    parameter int ROW_NUM = 32,
    parameter int WPR     = 8,
    parameter int BUS_W   = 32,
    parameter int RW      = idx_w(ROW_NUM),
    parameter int WW      = idx_w(WPR)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clr,
    input  logic                         we,
    input  logic [RW-1:0]                wr_row,
    input  logic [WW-1:0]                wr_word,
    input  logic [BUS_W-1:0]             wr_data,
    output logic [ROW_NUM*WPR*BUS_W-1:0] rd_data
);

    // Row-major word order makes the flat image identical to the PE layout.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            rd_data <= '0;
        else if (clr)
            rd_data <= '0;
        else if (we)
            rd_data[(32'(wr_row) * WPR + 32'(wr_word)) * BUS_W +: BUS_W] <= wr_data;

endmodule

// File: rtl/weight_pingpong_buffer.sv
// weight_pingpong_buffer: double-buffered PE weight store, standard and depthwise placement.
// Define WBUF_ERR_EN to add the err_sticky protocol-error flag.
module weight_pingpong_buffer
    import wbuf_pkg::*;
#(
    parameter int ROW_NUM = 32,
    parameter int COL_NUM = 32,
    parameter int DATA_W  = 8,
    parameter int BUS_W   = 32,
    parameter int KSIZE   = 3
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  cfg_valid,
    input  logic [1:0]                            cfg_mode,
    input  logic [$clog2(ROW_NUM):0]              cfg_rows,
    input  logic [$clog2(COL_NUM*DATA_W/BUS_W):0] cfg_words,
    input  logic                                  w_valid,
    output logic                                  w_ready,
    input  logic [BUS_W-1:0]                      w_data,
    input  logic                                  swap,
    output logic                                  bank_ready,
    output logic                                  load_busy,
    output logic [1:0]                            active_mode,
    output logic [ROW_NUM*COL_NUM*DATA_W-1:0]     weight_out
`ifdef WBUF_ERR_EN
    ,
    output logic                                  err_sticky
`endif
);

    localparam int N_WPR = calc_wpr(COL_NUM, DATA_W, BUS_W);
    localparam int N_DW  = calc_dw_rows(ROW_NUM, KSIZE);
    localparam int RW    = idx_w(ROW_NUM);
    localparam int WW    = idx_w(N_WPR);
    localparam int RCW   = $clog2(ROW_NUM) + 1;
    localparam int WCW   = $clog2(N_WPR) + 1;
    localparam int OUT_W = ROW_NUM * COL_NUM * DATA_W;
    localparam int NF    = ROW_NUM / KSIZE;

    wbuf_state_e    state, state_nx;
    wbuf_mode_e     ld_mode, act_mode;
    logic           act;
    logic [RCW-1:0] row_cnt, rows_lim, rows_clamp;
    logic [WCW-1:0] col_cnt, words_lim, words_clamp;
    logic           cfg_ok, hs, last, do_swap, accept, clr_sel, col_wrap;
    logic [OUT_W-1:0] rd [2];
    logic [OUT_W-1:0] act_rd, dw_out;

    assign cfg_ok  = cfg_valid && cfg_mode < 2'd2 && cfg_rows != '0 &&
                     (cfg_mode == MODE_DW || cfg_words != '0);
    assign hs       = state == LOAD && w_valid;
    assign col_wrap = col_cnt == words_lim - 1'b1;
    assign last     = hs && col_wrap && row_cnt == rows_lim - 1'b1;
    assign do_swap  = state == FULL && swap;
    assign accept   = cfg_ok && (state == IDLE || do_swap);
    // A back-to-back load refills the bank that is just leaving the array.
    assign clr_sel  = do_swap ? act : ~act;

    assign rows_clamp = (cfg_mode == MODE_DW) ?
                        ((cfg_rows > RCW'(N_DW)) ? RCW'(N_DW) : cfg_rows) :
                        ((cfg_rows > RCW'(ROW_NUM)) ? RCW'(ROW_NUM) : cfg_rows);
    assign words_clamp = (cfg_mode == MODE_DW) ? WCW'(1) :
                         ((cfg_words > WCW'(N_WPR)) ? WCW'(N_WPR) : cfg_words);

    assign w_ready     = state == LOAD;
    assign load_busy   = state == LOAD;
    assign bank_ready  = state == FULL;
    assign active_mode = act_mode;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? LOAD : IDLE;
            LOAD:    state_nx = last ? FULL : LOAD;
            FULL:    state_nx = swap ? (accept ? LOAD : IDLE) : FULL;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state     <= IDLE;
            act       <= 1'b0;
            ld_mode   <= MODE_STD;
            act_mode  <= MODE_STD;
            row_cnt   <= '0;
            col_cnt   <= '0;
            rows_lim  <= '0;
            words_lim <= '0;
        end else begin
            state <= state_nx;
            if (do_swap) begin
                act      <= ~act;
                act_mode <= ld_mode;
            end
            if (accept) begin
                ld_mode   <= wbuf_mode_e'(cfg_mode);
                rows_lim  <= rows_clamp;
                words_lim <= words_clamp;
                row_cnt   <= '0;
                col_cnt   <= '0;
            end else if (hs) begin
                col_cnt <= col_wrap ? '0 : col_cnt + 1'b1;
                row_cnt <= col_wrap ? row_cnt + 1'b1 : row_cnt;
            end
        end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        wbuf_bank #(
            .ROW_NUM(ROW_NUM),
            .WPR    (N_WPR),
            .BUS_W  (BUS_W)
        ) u_bank (
            .clk    (clk),
            .reset_n(reset_n),
            .clr    (accept && clr_sel == 1'(b)),
            .we     (hs && act != 1'(b)),
            .wr_row (row_cnt[RW-1:0]),
            .wr_word(col_cnt[WW-1:0]),
            .wr_data(w_data),
            .rd_data(rd[b])
        );
    end

    assign act_rd = rd[act];

    // Depthwise: stored row f*K+k carries taps j, placed on the diagonal block of kernel f.
    always_comb begin
        dw_out = '0;
        for (int f = 0; f < NF; f++)
            for (int k = 0; k < KSIZE; k++)
                for (int j = 0; j < KSIZE; j++)
                    if (f * KSIZE + j < COL_NUM)
                        dw_out[((f*KSIZE + k) * COL_NUM + f*KSIZE + j) * DATA_W +: DATA_W] =
                            act_rd[((f*KSIZE + k) * COL_NUM + j) * DATA_W +: DATA_W];
    end

    assign weight_out = (act_mode == MODE_DW) ? dw_out : act_rd;

`ifdef WBUF_ERR_EN
    logic err_ev;
    assign err_ev = (w_valid && state != LOAD) ||
                    (cfg_valid && (state == LOAD || (state == FULL && !swap)));

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            err_sticky <= 1'b0;
        else
            err_sticky <= (err_sticky && !accept) || err_ev;
`endif

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// tb_weight_pingpong_buffer: table-driven cfg checks, directed tiles and random tiles
// against an image-level reference model of both banks.
module tb_weight_pingpong_buffer;

    localparam int R = 32, C = 32, DWID = 8, BW = 32, K = 3;
    localparam int WPR = 8, DWR = 30, OW = R * C * DWID;

    logic          clk = 1'b0, reset_n = 1'b0, cfg_valid = 1'b0, w_valid = 1'b0, swap = 1'b0;
    logic [1:0]    cfg_mode = '0;
    logic [5:0]    cfg_rows = '0;
    logic [3:0]    cfg_words = '0;
    logic [BW-1:0] w_data = '0;
    logic          w_ready, bank_ready, load_busy;
    logic [1:0]    active_mode;
    logic [OW-1:0] weight_out;
`ifdef WBUF_ERR_EN
    logic          err_sticky;
`endif

    weight_pingpong_buffer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_valid  (cfg_valid),
        .cfg_mode   (cfg_mode),
        .cfg_rows   (cfg_rows),
        .cfg_words  (cfg_words),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data     (w_data),
        .swap       (swap),
        .bank_ready (bank_ready),
        .load_busy  (load_busy),
        .active_mode(active_mode),
        .weight_out (weight_out)
`ifdef WBUF_ERR_EN
        ,
        .err_sticky (err_sticky)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [5:0] rows;
        logic [3:0] words;
        logic       exp_busy;
    } cfg_vec_t;

    cfg_vec_t      tbl [8];
    int            pass_cnt = 0, chk_cnt = 0;
    logic [OW-1:0] exp_bank [2];
    logic [1:0]    exp_mode [2];
    int            exp_act;
    logic [31:0]   word_q [$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic chk_out(input string nm);
        logic [OW-1:0] e;
        int idx;
        e = exp_bank[exp_act];
        idx = -1;
        chk_cnt++;
        if (weight_out === e) pass_cnt++;
        else begin
            for (int i = 0; i < R * C; i++)
                if (idx < 0 && weight_out[i*DWID +: DWID] !== e[i*DWID +: DWID]) idx = i;
            $display("FAIL %s: PE(%0d,%0d) got %0h expected %0h", nm, idx / C, idx % C,
                     weight_out[idx*DWID +: DWID], e[idx*DWID +: DWID]);
        end
    endtask

    function automatic logic [7:0] pe(int r, int c);
        return weight_out[(r * C + c) * DWID +: DWID];
    endfunction

    function automatic int eff_rows(int mode, int rows);
        return (mode == 1) ? ((rows > DWR) ? DWR : rows) : ((rows > R) ? R : rows);
    endfunction

    function automatic int eff_words(int mode, int words);
        return (mode == 1) ? 1 : ((words > WPR) ? WPR : words);
    endfunction

    // Reference image: place the word list as a tile, then map it to PE positions.
    function automatic logic [OW-1:0] model_img(int mode, int rows, int words);
        logic [7:0]    img [R][C];
        logic [OW-1:0] o;
        int n;
        n = 0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) img[r][c] = 8'h0;
        for (int r = 0; r < eff_rows(mode, rows); r++)
            for (int w = 0; w < eff_words(mode, words); w++) begin
                for (int b = 0; b < 4; b++) img[r][w*4 + b] = word_q[n][b*8 +: 8];
                n++;
            end
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                o[(r*C + c)*DWID +: DWID] = (mode == 0) ? img[r][c] :
                    (r < DWR && r / K == c / K) ? img[r][c % K] : 8'h0;
        return o;
    endfunction

    task automatic gen_words(input int mode, input int rows, input int words, input bit pat);
        int nw;
        nw = eff_words(mode, words);
        word_q.delete();
        for (int i = 0; i < eff_rows(mode, rows) * nw; i++)
            word_q.push_back(pat ? {8'(i % nw), 8'(i / nw), 8'(i % nw), 8'(i / nw)} : $urandom);
    endtask

    task automatic model_reset();
        exp_bank[0] = '0;
        exp_bank[1] = '0;
        exp_mode[0] = 2'd0;
        exp_mode[1] = 2'd0;
        exp_act = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic load_tile(input int mode, input int rows, input int words,
                             input bit pre, input bit noise, input int abort_at);
        int n, sent, cyc, bad;
        n = eff_rows(mode, rows) * eff_words(mode, words);
        sent = 0;
        cyc = 0;
        bad = 0;
        if (!pre) begin
            @(negedge clk);
            cfg_valid = 1'b1;
            cfg_mode  = 2'(mode);
            cfg_rows  = 6'(rows);
            cfg_words = 4'(words);
            @(negedge clk);
            cfg_valid = 1'b0;
        end
        while (sent < n && cyc < 4000) begin
            if (abort_at > 0 && sent == abort_at) break;
            if (weight_out !== exp_bank[exp_act]) bad++;
            w_valid   = $urandom_range(0, 3) != 0;
            w_data    = word_q[sent];
            swap      = noise && $urandom_range(0, 5) == 0;
            cfg_valid = noise && $urandom_range(0, 5) == 0;
            cfg_mode  = 2'($urandom_range(0, 1));
            cfg_rows  = 6'($urandom_range(1, 32));
            cfg_words = 4'($urandom_range(1, 8));
            if (w_valid && w_ready) sent++;
            cyc++;
            @(negedge clk);
        end
        w_valid = 1'b0;
        swap = 1'b0;
        cfg_valid = 1'b0;
        chk("stable_out", bad, 0);
        if (abort_at == 0) begin
            chk("load_done", sent, n);
            chk("w_ready_full", w_ready, 0);
            chk("bank_ready_full", bank_ready, 1);
            chk("load_busy_full", load_busy, 0);
            chk_out("hold_in_full");
            exp_bank[1 - exp_act] = model_img(mode, rows, words);
            exp_mode[1 - exp_act] = 2'(mode);
        end
    endtask

    task automatic swap_tile();
        @(negedge clk);
        swap = 1'b1;
        @(negedge clk);
        swap = 1'b0;
        exp_act = 1 - exp_act;
        chk_out("swap_out");
        chk("active_mode", active_mode, exp_mode[exp_act]);
        chk("idle_after_swap", {bank_ready, load_busy}, 0);
    endtask

    task automatic swap_cfg(input int mode, input int rows, input int words);
        @(negedge clk);
        swap      = 1'b1;
        cfg_valid = 1'b1;
        cfg_mode  = 2'(mode);
        cfg_rows  = 6'(rows);
        cfg_words = 4'(words);
        @(negedge clk);
        swap = 1'b0;
        cfg_valid = 1'b0;
        exp_act = 1 - exp_act;
        chk("b2b_busy", load_busy, 1);
        chk_out("b2b_out");
        chk("b2b_mode", active_mode, exp_mode[exp_act]);
    endtask

    initial begin
        int mode, rows, words;
        bit pend;
        tbl = '{'{2'd0, 6'd0, 4'd1, 1'b0}, '{2'd0, 6'd1, 4'd0, 1'b0},
                '{2'd2, 6'd4, 4'd4, 1'b0}, '{2'd3, 6'd1, 4'd1, 1'b0},
                '{2'd1, 6'd5, 4'd0, 1'b1}, '{2'd0, 6'd32, 4'd8, 1'b1},
                '{2'd1, 6'd40, 4'd3, 1'b1}, '{2'd0, 6'd1, 4'd1, 1'b1}};

        do_reset();
        @(negedge clk);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_bank_ready", bank_ready, 0);
        chk("rst_load_busy", load_busy, 0);
        chk("rst_active_mode", active_mode, 0);
        chk_out("rst_out");

        for (int i = 0; i < 8; i++) begin
            do_reset();
            @(negedge clk);
            cfg_valid = 1'b1;
            cfg_mode  = tbl[i].mode;
            cfg_rows  = tbl[i].rows;
            cfg_words = tbl[i].words;
            @(negedge clk);
            cfg_valid = 1'b0;
            chk($sformatf("cfg%0d_busy", i), load_busy, 32'(tbl[i].exp_busy));
            chk($sformatf("cfg%0d_ready", i), w_ready, 32'(tbl[i].exp_busy));
            chk($sformatf("cfg%0d_bank", i), bank_ready, 0);
        end

        // Stray word in IDLE, then full standard tile.
        do_reset();
        @(negedge clk);
        w_valid = 1'b1;
        @(negedge clk);
        w_valid = 1'b0;
        chk("idle_wvalid_busy", load_busy, 0);
`ifdef WBUF_ERR_EN
        chk("err_set", err_sticky, 1);
`endif
        gen_words(0, 32, 8, 1);
        load_tile(0, 32, 8, 0, 0, 0);
`ifdef WBUF_ERR_EN
        chk("err_clear", err_sticky, 0);
`endif
        swap_tile();
        chk("pe_5_12", pe(5, 12), 32'h05);

        // Partial tile with gaps and ignored swap/cfg noise.
        gen_words(0, 2, 2, 0);
        load_tile(0, 2, 2, 0, 1, 0);
        swap_tile();
        chk("partial_pe_0_8", pe(0, 8), 0);

        // Depthwise with clamped row count.
        gen_words(1, 40, 0, 0);
        word_q[4] = 32'h000C0B0A;
        load_tile(1, 40, 0, 0, 0, 0);
        swap_tile();
        chk("dw_pe_4_3", pe(4, 3), 32'h0A);
        chk("dw_pe_4_4", pe(4, 4), 32'h0B);
        chk("dw_pe_4_5", pe(4, 5), 32'h0C);
        chk("dw_pe_4_6", pe(4, 6), 0);
        chk("dw_mode", active_mode, 1);

        // Back-to-back tiles: swap and new cfg in the same FULL cycle.
        gen_words(0, 16, 5, 0);
        load_tile(0, 16, 5, 0, 1, 0);
        swap_cfg(1, 12, 0);
        gen_words(1, 12, 0, 0);
        load_tile(1, 12, 0, 1, 1, 0);
        swap_tile();

        // Async reset in the middle of a load.
        gen_words(0, 32, 8, 0);
        load_tile(0, 32, 8, 0, 0, 100);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk_out("async_rst_out");
        chk("async_rst_w_ready", w_ready, 0);
        chk("async_rst_bank_ready", bank_ready, 0);
        chk("async_rst_busy", load_busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        gen_words(0, 32, 8, 1);
        load_tile(0, 32, 8, 0, 0, 0);
        swap_tile();

        // Random tiles, randomly chained back-to-back.
        pend = 1'b0;
        mode = 0;
        rows = 1;
        words = 1;
        for (int t = 0; t < 8; t++) begin
            if (!pend) begin
                mode  = $urandom_range(0, 1);
                rows  = (mode == 1) ? $urandom_range(1, 40) : $urandom_range(1, 32);
                words = $urandom_range(1, 8);
            end
            gen_words(mode, rows, words, 0);
            load_tile(mode, rows, words, pend, 1, 0);
            mode  = $urandom_range(0, 1);
            rows  = (mode == 1) ? $urandom_range(1, 40) : $urandom_range(1, 32);
            words = $urandom_range(1, 8);
            if (t < 7 && $urandom_range(0, 1) == 1) begin
                swap_cfg(mode, rows, words);
                pend = 1'b1;
            end else begin
                swap_tile();
                pend = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/weight_pingpong_buffer.md
Name: weight_pingpong_buffer

Overview:
- Parametrised, double-buffered successor to the horizontal weight buffer feeding the PE array.
- A BUS_W-wide valid/ready stream loads a shadow bank while the active bank drives the PE array.
- A swap request exchanges the banks, so the next tile's weights load while the current tile computes.
- Supports standard/pointwise row fill and depthwise diagonal KSIZE×KSIZE placement.

Parameters:
ROW_NUM, 32, PE array rows
COL_NUM, 32, PE array columns
DATA_W, 8, bits per weight
BUS_W, 32, input word width; WPR = COL_NUM*DATA_W/BUS_W words per row (8); must divide evenly
KSIZE, 3, depthwise kernel size; DW_ROWS = (ROW_NUM/KSIZE)*KSIZE (30)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cfg_valid  in  1  start-load pulse; cfg_* sampled with it
cfg_mode  in  2  0=standard, 1=depthwise, 2/3 reserved
cfg_rows  in  $clog2(ROW_NUM)+1  rows to load, 1..ROW_NUM
cfg_words  in  $clog2(WPR)+1  words per row, 1..WPR (standard mode only)
w_valid  in  1  weight word valid
w_ready  out  1  buffer accepts word
w_data  in  BUS_W  weight word
swap  in  1  consumer request to make shadow bank active
bank_ready  out  1  shadow bank fully loaded
load_busy  out  1  FSM in LOAD
active_mode  out  2  mode of the bank driving weight_out
weight_out  out  ROW_NUM*COL_NUM*DATA_W  PE(r,c) at [(r*COL_NUM+c)*DATA_W +: DATA_W]

Behaviour:
- Reset (async, any time incl. mid-load): state IDLE, both banks zero, active pointer 0, counters 0, w_ready=0, bank_ready=0, load_busy=0, active_mode=0, weight_out=0.
- States: IDLE, LOAD, FULL.
- IDLE:
  - cfg_valid with legal cfg (mode 0/1, cfg_rows≠0, cfg_words≠0 in mode 0) → latch cfg, synchronously zero the shadow bank, clear counters, go to LOAD next cycle.
  - Illegal cfg is ignored; stay IDLE.
- LOAD:
  - w_ready=1, load_busy=1.
  - Handshake = w_valid & w_ready; one word is written per handshake, no bubbles.
  - Standard mode: word goes to shadow[row_cnt][col_cnt]. Word w of row r covers cols w*(BUS_W/DATA_W).. ascending, LSB = lowest column. col_cnt wraps at cfg_words-1, then row_cnt increments. Columns of unwritten words stay zero.
  - Depthwise mode: one word per row; row_cnt increments per handshake. Effective rows = min(cfg_rows, DW_ROWS), clamped at latch.
  - Handshake on the last word → FULL.
- FULL:
  - w_ready=0, bank_ready=1.
  - swap → toggle active pointer, active_mode ← latched mode. Takes effect on weight_out the next cycle.
  - swap together with legal cfg_valid → swap and go directly to LOAD with the new cfg (back-to-back tiles); otherwise → IDLE.
- swap in IDLE/LOAD: ignored, no toggle.
- cfg_valid in LOAD, or in FULL without swap: ignored.
- Output mapping (combinational from active bank):
  - Mode 0: PE(r,c) = stored byte.
  - Mode 1: stored row i = f*KSIZE+k holds kernel f, tap row k, tap j at bits [j*DATA_W +: DATA_W]. PE(f*KSIZE+k, f*KSIZE+j) = tap j; all other PEs 0. Bits above KSIZE*DATA_W are ignored.
- The active bank is never written; weight_out is stable during loads.

Optional Feature:
- Macro WBUF_ERR_EN.
- Defined: adds output err_sticky (1 bit, reset 0). Set on w_valid while state ≠ LOAD, or on cfg_valid ignored because state is LOAD/FULL. Cleared when a legal cfg_valid is accepted.
- Undefined: port absent; those events are silently ignored.

Decomposition:
- Package wbuf_pkg:
  - wbuf_mode_e {MODE_STD, MODE_DW}
  - wbuf_state_e {IDLE, LOAD, FULL}
  - localparams WPR and DW_ROWS, and width helpers.
- Sub-module wbuf_bank: ROW_NUM×WPR×BUS_W storage, one write port, synchronous clear, flat read-out; instantiated twice. FSM, counters and the DW mapping live in the top module.

Test Plan:
- Standard load: cfg_rows=32, cfg_words=8, 256 words with data = {row,col,row,col} bytes → bank_ready after word 256; after swap, weight_out byte at PE(5,12) = 0x05.
- Partial load: cfg_rows=2, cfg_words=2, words A0,A1,B0,B1 with w_valid gaps → row 0 cols 0-7 from A0/A1, cols 8-31 = 0; rows 2-31 = 0; w_ready drops after the 4th handshake.
- Depthwise: cfg_mode=1, cfg_rows=40 → clamped to 30 accepts. Word 4 = 0x00_0C_0B_0A → PE(4,3)=0x0A, PE(4,4)=0x0B, PE(4,5)=0x0C; PE(4,6)=0; active_mode=1.
- Ping-pong: load bank A, swap; during the bank B load, weight_out stays at bank A values every cycle. Swap plus cfg_valid in the same FULL cycle → next cycle load_busy=1, weight_out = B.
- Ignore rules: swap during LOAD → no change. cfg_valid with cfg_rows=0 → stays IDLE. With WBUF_ERR_EN, w_valid in IDLE sets err_sticky=1, and the next legal cfg_valid clears it.
- Async reset: assert reset_n=0 after 100 of 256 words → weight_out=0, w_ready=0, bank_ready=0 immediately. Reload after release completes normally.
